// File: rtl/fifo_destino.sv
// Destination FIFO: circular buffer between the routing stage and the downstream consumer.
// Latency: registered read, data_out/valid_out one cycle after an accepted pop.
// Backpressure: pause at occupancy >= UMBRAL_ALTO; push on full without pop is dropped.
//
// Optional build macro: FIFO_DESTINO_ERR_EN
//   defined   -> error is a sticky flag set by any rejected push or pop, cleared by reset
//   undefined -> error is tied low and no error logic exists
//
// Ports:
//   clk           sole clock, rising edge
//   reset         synchronous, active-high
//   push/data_in  write request and word from the routing stage
//   pop           read request from the consumer
//   data_out      registered read word (holds last value when no pop)
//   valid_out     data_out carries a word popped at the previous edge
//   full/empty    occupancy == DEPTH / occupancy == 0
//   pause         occupancy >= UMBRAL_ALTO (back-pressure upstream)
//   almost_empty  occupancy <= UMBRAL_BAJO
//   error         overflow/underflow flag (see macro above)
//
// DEPTH must be a power of two and at least 4: pointers wrap by natural
// binary overflow, and the count keeps one extra bit to represent DEPTH.
module fifo_destino #(
    parameter int DATA_W      = 6,
    parameter int DEPTH       = 8,
    parameter int UMBRAL_ALTO = 6,
    parameter int UMBRAL_BAJO = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] data_in,
    input  logic              pop,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              full,
    output logic              empty,
    output logic              pause,
    output logic              almost_empty,
    output logic              error
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] L_ALTO  = CW'(UMBRAL_ALTO);
    localparam logic [CW-1:0] L_BAJO  = CW'(UMBRAL_BAJO);

    // Storage and pointers
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    // Registered read port
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid_out;

    // Decodes and handshake qualifiers
    logic w_full;
    logic w_empty;
    logic w_pop_acc;
    logic w_push_acc;

    // Status flags depend on the count register only, never on the same-cycle
    // request lines, so upstream sees a glitch-free registered decode.
    assign w_full  = (r_count == L_DEPTH);
    assign w_empty = (r_count == '0);

    assign w_pop_acc  = pop & ~w_empty;
    // A full FIFO can still take a word when a pop frees a slot on the same
    // edge; the pop reads the old rd_ptr slot, the push writes the wr_ptr slot,
    // and when full these are the same slot, read before overwrite.
    assign w_push_acc = push & (~w_full | w_pop_acc);

    // Memory: no reset needed, content is only ever read behind the count.
    always_ff @(posedge clk) begin
        if (!reset && w_push_acc) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Read port: valid_out is a one-cycle pulse per accepted pop, data_out
    // keeps the last popped word between pops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_pop_acc;
            if (w_pop_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

`ifdef FIFO_DESTINO_ERR_EN
    // Sticky overflow/underflow flag. A pop against an empty FIFO counts as
    // rejected even when a concurrent push is accepted.
    logic w_push_rej;
    logic w_pop_rej;
    logic r_error;

    assign w_push_rej = push & ~w_push_acc;
    assign w_pop_rej  = pop & w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_error <= 1'b0;
        end else if (w_push_rej | w_pop_rej) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    assign data_out     = r_data_out;
    assign valid_out    = r_valid_out;
    assign full         = w_full;
    assign empty        = w_empty;
    assign pause        = (r_count >= L_ALTO);
    assign almost_empty = (r_count <= L_BAJO);

endmodule

// File: tb/tb_fifo_destino.sv
// Self-checking bench for fifo_destino: queue-based reference model plus directed literals.
// Latency: every stimulus step is one clock; outputs compared 1 time unit after the edge.
// Backpressure: model drops pushes on full without pop and ignores pops on empty.
module tb_fifo_destino;

    localparam int DATA_W = 6;
    localparam int DEPTH  = 8;
    localparam int HI     = 6;
    localparam int LO     = 1;

`ifdef FIFO_DESTINO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              push = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              pop = 1'b0;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              full;
    logic              empty;
    logic              pause;
    logic              almost_empty;
    logic              error;

    fifo_destino #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .UMBRAL_ALTO (HI),
        .UMBRAL_BAJO (LO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .pause        (pause),
        .almost_empty (almost_empty),
        .error        (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_dout = '0;
    logic              m_vld  = 1'b0;
    logic              m_err  = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare every DUT output against the model after each edge.
    task automatic compare_all();
        int n;
        n = q.size();
        chk("data_out",     32'(data_out),     32'(m_dout));
        chk("valid_out",    32'(valid_out),    32'(m_vld));
        chk("full",         32'(full),         32'(n == DEPTH));
        chk("empty",        32'(empty),        32'(n == 0));
        chk("pause",        32'(pause),        32'(n >= HI));
        chk("almost_empty", 32'(almost_empty), 32'(n <= LO));
        chk("error",        32'(error),        32'(ERR_EN & m_err));
    endtask

    // One clock of stimulus: the model advances from the queue contents as
    // they stand before the edge, then the DUT is compared after the edge.
    task automatic step(input logic rst, input logic ps, input logic [DATA_W-1:0] d,
                        input logic pp);
        bit pop_ok;
        bit push_ok;
        reset   = rst;
        push    = ps;
        data_in = d;
        pop     = pp;
        if (rst) begin
            q.delete();
            m_dout = '0;
            m_vld  = 1'b0;
            m_err  = 1'b0;
        end else begin
            pop_ok  = pp && (q.size() > 0);
            push_ok = ps && ((q.size() < DEPTH) || pop_ok);
            m_vld   = pop_ok;
            if (pop_ok)  m_dout = q.pop_front();
            if (push_ok) q.push_back(d);
            if ((ps && !push_ok) || (pp && !pop_ok)) m_err = 1'b1;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        // Reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_almost_empty", 32'(almost_empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_pause", 32'(pause), 0);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_dout", 32'(data_out), 0);

        // Fill with 1..8, pause from count 6
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, DATA_W'(k), 0);
            chk("fill_pause", 32'(pause), 32'(k >= 6));
            chk("fill_empty", 32'(empty), 0);
        end
        chk("fill_full", 32'(full), 1);
        // Drain, each word one cycle after its pop
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 0, 1);
            chk("drain_vld", 32'(valid_out), 1);
            chk("drain_dout", 32'(data_out), 32'(k));
        end
        step(0, 0, 0, 0);
        chk("drain_vld_idle", 32'(valid_out), 0);
        chk("drain_dout_hold", 32'(data_out), 8);
        chk("drain_empty", 32'(empty), 1);

        // Simultaneous push+pop on full
        for (int k = 1; k <= 8; k++) step(0, 1, DATA_W'(k), 0);
        step(0, 1, 6'h3F, 1);
        chk("fullpp_dout", 32'(data_out), 1);
        chk("fullpp_full", 32'(full), 1);
        for (int k = 2; k <= 8; k++) step(0, 0, 0, 1);
        chk("fullpp_dout8", 32'(data_out), 8);
        step(0, 0, 0, 1);
        chk("fullpp_last", 32'(data_out), 32'h3F);
        chk("fullpp_empty", 32'(empty), 1);

        // Simultaneous push+pop on empty
        step(1, 0, 0, 0);
        step(0, 1, 6'h15, 1);
        chk("emptypp_vld", 32'(valid_out), 0);
        chk("emptypp_empty", 32'(empty), 0);
        chk("emptypp_ae", 32'(almost_empty), 1);
        chk("emptypp_err", 32'(error), 32'(ERR_EN));
        step(0, 0, 0, 1);
        chk("emptypp_read", 32'(data_out), 32'h15);

        // Overflow on full: word dropped, sticky error when enabled
        step(1, 0, 0, 0);
        for (int k = 1; k <= 8; k++) step(0, 1, DATA_W'(k), 0);
        chk("ovf_err_before", 32'(error), 0);
        step(0, 1, 6'h2A, 0);
        chk("ovf_err", 32'(error), 32'(ERR_EN));
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 0, 1);
            chk("ovf_read", 32'(data_out), 32'(k));
        end
        chk("ovf_err_sticky", 32'(error), 32'(ERR_EN));
        step(1, 0, 0, 0);
        chk("ovf_err_cleared", 32'(error), 0);

        // Steady stream of 20 words across pointer wrap, reset mid-stream
        step(0, 1, 6'd1, 0);
        for (int k = 2; k <= 20; k++) begin
            step(0, 1, DATA_W'(k), 1);
            chk("stream_dout", 32'(data_out), 32'(k - 1));
        end
        step(1, 1, 6'd33, 1);
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_vld", 32'(valid_out), 0);

        // Randomized traffic with phases biased toward filling and draining
        for (int i = 0; i < 2000; i++) begin
            int pp_w;
            int ps_w;
            logic rr;
            ps_w = ((i / 100) % 2 == 0) ? 75 : 35;
            pp_w = 100 - ps_w;
            rr   = ($urandom_range(0, 299) == 0);
            step(rr, ($urandom_range(0, 99) < ps_w), DATA_W'($urandom),
                 ($urandom_range(0, 99) < pp_w));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
